fp_div_iter: RTL
================

Name: fp_div_iter

Overview:
- Parametrised IEEE-754-style floating-point divider; next generation of the single-precision divider.
- Field widths are configurable. Uses a valid/ready handshake on input and output.
- Full special-case handling (NaN, Inf, zero) with IEEE exception flags.
- Iterative radix-2 restoring mantissa core producing one quotient bit per cycle. Sits between operand registers and the FP result bus of the arithmetic unit.

Parameters:
- EXP_W, 8, exponent field width (3..11).
- MANT_W, 23, stored fraction width (4..52); word width W = 1+EXP_W+MANT_W.
- BIAS, 2**(EXP_W-1)-1, exponent bias.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operands a/b present.
- in_ready  out  1  block can accept operands.
- a  in  W  dividend {sign, exp, frac}.
- b  in  W  divisor {sign, exp, frac}.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  quotient a/b.
- flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- While reset is high: state=IDLE, in_ready=0, out_valid=0, result=0, flags=0. Reset mid-operation aborts the division silently; in_ready=1 on the first cycle after reset falls.
- FSM states: IDLE -> PREP -> DIV -> NORM -> DONE -> IDLE. PREP jumps straight to DONE for special cases.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a/b -> PREP.
  - PREP (1 cycle): classify operands; form sign = sa^sb and exponent e = ea-eb+BIAS (signed, EXP_W+2 bits); load significands {1,fa}, {1,fb}.
  - DIV: exactly MANT_W+4 cycles, one quotient bit per cycle (MSB first); down-counter from MANT_W+3 to 0; sticky = final remainder != 0.
  - NORM (1 cycle): if the quotient MSB is 0 (mantissa ratio < 1), shift left 1 and e -= 1. Round, then pack. Rounding carry-out renormalises and increments e.
  - DONE: out_valid=1. result/flags held stable until out_ready. out_valid&&out_ready -> IDLE, with in_ready=1 the next cycle. No back-to-back acceptance.
- Latency from the acceptance edge to out_valid: special case 1 cycle; normal case MANT_W+6 cycles (29 for default).
- Denormal-as-zero: input exp==0 is treated as ±0 regardless of fraction. No subnormal outputs.
- Special cases (priority order, checked in PREP):
  - Either operand NaN -> canonical qNaN {0, all-ones, 1 followed by zeros}, invalid=1.
  - 0/0 or Inf/Inf -> qNaN, invalid=1.
  - Inf/x -> ±Inf.
  - x/0 with x finite nonzero -> ±Inf, div_by_zero=1.
  - x/Inf -> ±0.
  - 0/x -> ±0.
  - Special cases never set inexact.
- Overflow: final e >= 2**EXP_W-1 -> ±Inf, overflow=1, inexact=1.
- Underflow: final e <= 0 -> ±0, underflow=1, inexact=1.
- Flag clearing: flags cleared on every acceptance; each flag valid only while out_valid.

Optional Feature:
- Macro FP_DIV_ITER_RNE_EN.
- Defined: round-to-nearest-even using guard, round and sticky; inexact = G|R|S.
- Undefined: truncate toward zero; guard/round/sticky used only for inexact. The round-increment adder is not synthesised.

Decomposition:
- Package fp_div_pkg:
  - state enum {IDLE, PREP, DIV, NORM, DONE};
  - flag bit index constants;
  - functions for exp-all-ones, canonical qNaN and ±Inf/±0 assembly, parametrised by EXP_W/MANT_W.
- One sub-module, fp_div_mant_core:
  - iterative restoring significand divider with start/busy/done;
  - outputs the quotient register and sticky bit;
  - owns the iteration counter.
- Top-level keeps the handshake FSM, classification, exponent and rounding.

Test Plan:
- 6.0/2.0 (0x40C00000 / 0x40000000), out_ready=1 -> result 0x40400000, flags 0, out_valid exactly 29 cycles after accept.
- 1.0/3.0 (0x3F800000 / 0x40400000) -> 0x3EAAAAAB with RNE (0x3EAAAAAA with the macro off), inexact=1.
- 5.0/0.0 (0x40A00000 / 0x00000000) -> 0x7F800000, div_by_zero=1, out_valid 1 cycle after accept.
- 0/0 and Inf/Inf -> 0x7FC00000, invalid=1; NaN operand 0xFFC00001 / 1.0 -> 0x7FC00000, invalid=1.
- Exponent limits:
  - 0x7F000000 / 0x3E800000 (2^127 / 0.25) -> 0x7F800000, overflow=1, inexact=1;
  - 0x00800000 / 0x40000000 (2^-126 / 2) -> 0x00000000, underflow=1, inexact=1.
- Handshake and reset:
  - hold out_ready=0 for 10 cycles: result stable, in_ready=0, a new in_valid is ignored;
  - assert reset mid-DIV: next cycle out_valid=0, then in_ready=1 and a fresh 6.0/2.0 completes correctly.

Source files
------------

// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared types, constants and word-assembly helpers for the
// iterative floating-point divider (fp_div_iter) and its significand core.
//
// Contents:
//   state_t          handshake/sequencing states of the divider
//   FLAG_*           bit positions inside the 5-bit flags word
//                    {invalid, div_by_zero, overflow, underflow, inexact}
//   exp_all_ones()   test an exponent field (up to 11 bits) for all ones
//   canonical_qnan() {0, all-ones exponent, 1 followed by zeros}
//   pack_inf_zero()  signed infinity or signed zero
//
// The helpers take the field widths as arguments and return a 64-bit word
// (the widest legal format). Callers cast the result down to their width.
package fp_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIV,
    NORM,
    DONE
  } state_t;

  localparam int FLAGS_W      = 5;
  localparam int FLAG_INVALID = 4;
  localparam int FLAG_DBZ     = 3;
  localparam int FLAG_OVF     = 2;
  localparam int FLAG_UNF     = 1;
  localparam int FLAG_INEXACT = 0;

  // Only the low exp_w bits of e take part in the test.
  function automatic logic exp_all_ones(input logic [10:0] e, input int exp_w);
    logic ones;
    ones = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i < exp_w && !e[i]) ones = 1'b0;
    end
    return ones;
  endfunction

  function automatic logic [63:0] canonical_qnan(input int exp_w, input int mant_w);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 11; i++) begin
      if (i < exp_w) w = w | (64'd1 << (mant_w + i));
    end
    w = w | (64'd1 << (mant_w - 1));
    return w;
  endfunction

  // inf=1 gives +/-Inf, inf=0 gives +/-0.
  function automatic logic [63:0] pack_inf_zero(input logic sign, input logic inf,
                                                 input int exp_w, input int mant_w);
    logic [63:0] w;
    w = '0;
    if (inf) begin
      for (int i = 0; i < 11; i++) begin
        if (i < exp_w) w = w | (64'd1 << (mant_w + i));
      end
    end
    if (sign) w = w | (64'd1 << (exp_w + mant_w));
    return w;
  endfunction

endpackage

// File: rtl/fp_div_mant_core.sv
// fp_div_mant_core: iterative radix-2 restoring significand divider.
//
// Divides two normalised significands {1, frac} (each MANT_W+1 bits, value in
// [1,2)) and produces MANT_W+4 quotient bits, MSB first, one per clock. The
// MSB is the integer bit of the ratio (so it is 0 when dividend < divisor).
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           load operands and begin (ignored handshake-wise while busy)
//   dividend        {1, frac_a}
//   divisor         {1, frac_b}
//   busy            iteration in progress
//   done            high during the cycle that produces the final quotient bit
//   quotient        quotient register (complete once busy has fallen)
//   sticky          final partial remainder is non-zero
module fp_div_mant_core
  import fp_div_pkg::*;
#(
  parameter int MANT_W = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MANT_W:0]   dividend,
  input  logic [MANT_W:0]   divisor,
  output logic              busy,
  output logic              done,
  output logic [MANT_W+3:0] quotient,
  output logic              sticky
);

  localparam int N     = MANT_W + 4;
  localparam int CNT_W = $clog2(N);
  // The partial remainder is always below twice the divisor.
  localparam int REM_W = MANT_W + 2;

  logic [REM_W-1:0] rem_reg;
  logic [MANT_W:0]  div_reg;
  logic [CNT_W-1:0] count_reg;
  logic             busy_reg;
  logic [N-1:0]     quo_reg;

  logic [REM_W:0]   diff;
  logic             q_bit;
  logic [REM_W-1:0] rem_next;
  logic             unused_rem_msb;

  always_comb begin
    diff     = {1'b0, rem_reg} - {2'b00, div_reg};
    q_bit    = ~diff[REM_W];
    rem_next = q_bit ? diff[REM_W-1:0] : rem_reg;
  end

  // After the restore step the remainder is below the divisor, so its top
  // bit is always zero and the left shift cannot lose information.
  assign unused_rem_msb = rem_next[REM_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_reg   <= '0;
      div_reg   <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      quo_reg   <= '0;
    end else if (start) begin
      rem_reg   <= {1'b0, dividend};
      div_reg   <= divisor;
      count_reg <= CNT_W'(N - 1);
      busy_reg  <= 1'b1;
      quo_reg   <= '0;
    end else if (busy_reg) begin
      quo_reg   <= {quo_reg[N-2:0], q_bit};
      rem_reg   <= {rem_next[REM_W-2:0], 1'b0};
      count_reg <= count_reg - 1'b1;
      if (count_reg == '0) busy_reg <= 1'b0;
    end
  end

  assign busy     = busy_reg;
  assign done     = busy_reg && (count_reg == '0);
  assign quotient = quo_reg;
  assign sticky   = (rem_reg != '0);

endmodule

// File: rtl/fp_div_iter.sv
// fp_div_iter: parametrised IEEE-754-style floating-point divider with an
// iterative (one quotient bit per clock) restoring significand core.
//
// Ports (W = 1+EXP_W+MANT_W):
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   operands a/b present
//   in_ready   divider can accept operands (IDLE only)
//   a, b       dividend / divisor {sign, exp, frac}
//   out_valid  result/flags valid (held until out_ready)
//   out_ready  consumer accepts result
//   result     quotient a/b
//   flags      {invalid, div_by_zero, overflow, underflow, inexact}
//
// Sequence: IDLE -> PREP -> DIV (MANT_W+4 cycles) -> NORM -> DONE -> IDLE;
// special operands go PREP -> DONE directly. Inputs with a zero exponent are
// treated as signed zero and no subnormal is ever produced.
//
// Build option: define FP_DIV_ITER_RNE_EN for round-to-nearest-even;
// otherwise results are truncated toward zero (guard/round/sticky then only
// feed the inexact flag).
module fp_div_iter
  import fp_div_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int BIAS   = 2**(EXP_W-1) - 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W:0]   a,
  input  logic [EXP_W+MANT_W:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   result,
  output logic [FLAGS_W-1:0]      flags
);

  localparam int W     = 1 + EXP_W + MANT_W;
  localparam int N     = MANT_W + 4;
  localparam int EW2   = EXP_W + 2;
  localparam int SIG_W = MANT_W + 1;

  localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] ONE_S   = EW2'(1);

  state_t                 state_reg;
  logic [W-1:0]           a_reg;
  logic [W-1:0]           b_reg;
  logic                   sign_reg;
  logic signed [EW2-1:0]  exp_reg;
  logic [W-1:0]           result_reg;
  logic [FLAGS_W-1:0]     flags_reg;
  logic                   in_ready_reg;
  logic                   out_valid_reg;

  // ---------------------------------------------------------------------
  // Operand classification (evaluated from the latched operands in PREP)
  // ---------------------------------------------------------------------
  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] fa, fb;
  logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic              sign_prep;
  logic signed [EW2-1:0] exp_prep;

  always_comb begin
    ea        = a_reg[MANT_W +: EXP_W];
    eb        = b_reg[MANT_W +: EXP_W];
    fa        = a_reg[MANT_W-1:0];
    fb        = b_reg[MANT_W-1:0];
    zero_a    = (ea == '0);
    zero_b    = (eb == '0);
    inf_a     = exp_all_ones(11'(ea), EXP_W) && (fa == '0);
    inf_b     = exp_all_ones(11'(eb), EXP_W) && (fb == '0);
    nan_a     = exp_all_ones(11'(ea), EXP_W) && (fa != '0);
    nan_b     = exp_all_ones(11'(eb), EXP_W) && (fb != '0);
    sign_prep = a_reg[W-1] ^ b_reg[W-1];
    // Modular arithmetic in EW2 bits yields the two's-complement value.
    exp_prep  = EW2'({2'b00, ea} - {2'b00, eb} + EW2'(BIAS));
  end

  logic               special;
  logic [W-1:0]       special_result;
  logic [FLAGS_W-1:0] special_flags;

  // Priority order matters: NaN/invalid first, then Inf dividend, then the
  // zero divisor, then the results that collapse to zero.
  always_comb begin
    special        = 1'b1;
    special_result = '0;
    special_flags  = '0;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      special_result              = W'(canonical_qnan(EXP_W, MANT_W));
      special_flags[FLAG_INVALID] = 1'b1;
    end else if (inf_a) begin
      special_result = W'(pack_inf_zero(sign_prep, 1'b1, EXP_W, MANT_W));
    end else if (zero_b) begin
      special_result          = W'(pack_inf_zero(sign_prep, 1'b1, EXP_W, MANT_W));
      special_flags[FLAG_DBZ] = 1'b1;
    end else if (inf_b || zero_a) begin
      special_result = W'(pack_inf_zero(sign_prep, 1'b0, EXP_W, MANT_W));
    end else begin
      special = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Significand core
  // ---------------------------------------------------------------------
  logic         core_start;
  logic         core_busy;
  logic         core_done;
  logic [N-1:0] core_quo;
  logic         core_sticky;

  assign core_start = (state_reg == PREP) && !special;

  fp_div_mant_core #(
    .MANT_W (MANT_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (core_start),
    .dividend ({1'b1, fa}),
    .divisor  ({1'b1, fb}),
    .busy     (core_busy),
    .done     (core_done),
    .quotient (core_quo),
    .sticky   (core_sticky)
  );

  // ---------------------------------------------------------------------
  // Normalise, round, range-check and pack
  // ---------------------------------------------------------------------
  logic [N-1:0]          q_norm;
  logic signed [EW2-1:0] exp_norm;
  logic signed [EW2-1:0] exp_rnd;
  logic [MANT_W-1:0]     frac_rnd;
  logic                  g_bit, r_bit, s_bit;
  logic [W-1:0]          norm_result;
  logic [FLAGS_W-1:0]    norm_flags;

  // A zero quotient MSB means the significand ratio was below 1: one left
  // shift restores the leading 1 and costs one exponent step. The bit shifted
  // in is zero, so sticky then depends only on the remainder.
  always_comb begin
    q_norm   = core_quo[N-1] ? core_quo : {core_quo[N-2:0], 1'b0};
    exp_norm = core_quo[N-1] ? exp_reg : (exp_reg - ONE_S);
    g_bit    = q_norm[2];
    r_bit    = q_norm[1];
    s_bit    = q_norm[0] | core_sticky;
  end

`ifdef FP_DIV_ITER_RNE_EN
  logic [SIG_W-1:0] mant;
  logic             round_up;
  logic [SIG_W:0]   mant_sum;
  logic [1:0]       unused_bits;

  always_comb begin
    mant     = q_norm[N-1 -: SIG_W];
    round_up = g_bit & (r_bit | s_bit | mant[0]);
    mant_sum = {1'b0, mant} + {{SIG_W{1'b0}}, round_up};
    // Carry out means the significand rounded up to 2.0: renormalise to
    // 1.000... and bump the exponent.
    if (mant_sum[SIG_W]) begin
      frac_rnd = '0;
      exp_rnd  = exp_norm + ONE_S;
    end else begin
      frac_rnd = mant_sum[MANT_W-1:0];
      exp_rnd  = exp_norm;
    end
  end

  assign unused_bits = {core_busy, mant_sum[MANT_W]};
`else
  logic [1:0] unused_bits;

  always_comb begin
    frac_rnd = q_norm[N-2 -: MANT_W];
    exp_rnd  = exp_norm;
  end

  assign unused_bits = {core_busy, q_norm[N-1]};
`endif

  always_comb begin
    norm_flags               = '0;
    norm_flags[FLAG_INEXACT] = g_bit | r_bit | s_bit;
    norm_result              = {sign_reg, exp_rnd[EXP_W-1:0], frac_rnd};
    if (exp_rnd >= EXP_MAX) begin
      norm_result              = W'(pack_inf_zero(sign_reg, 1'b1, EXP_W, MANT_W));
      norm_flags[FLAG_OVF]     = 1'b1;
      norm_flags[FLAG_INEXACT] = 1'b1;
    end else if (exp_rnd <= 0) begin
      norm_result              = W'(pack_inf_zero(sign_reg, 1'b0, EXP_W, MANT_W));
      norm_flags[FLAG_UNF]     = 1'b1;
      norm_flags[FLAG_INEXACT] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Handshake FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sign_reg      <= 1'b0;
      exp_reg       <= '0;
      result_reg    <= '0;
      flags_reg     <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (in_valid && in_ready_reg) begin
            a_reg        <= a;
            b_reg        <= b;
            flags_reg    <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= PREP;
          end
        end
        PREP: begin
          sign_reg <= sign_prep;
          exp_reg  <= exp_prep;
          if (special) begin
            result_reg    <= special_result;
            flags_reg     <= special_flags;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            state_reg <= DIV;
          end
        end
        DIV: begin
          if (core_done) state_reg <= NORM;
        end
        NORM: begin
          result_reg    <= norm_result;
          flags_reg     <= norm_flags;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flags     = flags_reg;

endmodule
